div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
// - Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// - Produces the E-stage ALU stall consumed by the hazard unit; reacts to that unit's flushE and cache stalls.
// - Writes results to HI/LO: hi_o = remainder, lo_o = quotient.
// - One instruction in flight. A held instruction is never re-executed.
// PARAMETERS
// - WIDTH   32   operand/result width; iteration count = WIDTH
// PORTS
// - clk             in   1      clock, rising edge
// - resetn          in   1      asynchronous active-low reset
// - div_startE      in   1      E-stage instruction is DIV/DIVU; held high while it sits in E
// - div_signedE     in   1      1 = DIV (signed), 0 = DIVU
// - src_aE          in   WIDTH  dividend
// - src_bE          in   WIDTH  divisor
// - flushE          in   1      cancel the E-stage instruction
// - stall_ext       in   1      pipeline held by I/D-cache stall; E instruction does not advance
// - div_stallE      out  1      result not ready; drives alu_stallE
// - div_validE      out  1      hi_o/lo_o valid for the current E instruction
// - hi_o            out  WIDTH  remainder
// - lo_o            out  WIDTH  quotient
// BEHAVIOUR
// - Reset (async, resetn=0):
//   - state=IDLE, count=0.
//   - div_stallE=0, div_validE=0, hi_o=0, lo_o=0.
// - FSM states: IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE:
//     - If div_startE & ~flushE: latch |a|, |b|, sign_q = a[W-1]^b[W-1] (signed only), sign_r = a[W-1] (signed only).
//     - Clear partial remainder; count=0; go to BUSY.
//   - BUSY:
//     - Each cycle: shift the remainder:quotient pair left one bit.
//     - If remainder >= |b|, subtract |b| and set the quotient LSB.
//     - count++. When count==WIDTH-1, go to DONE.
//   - DONE:
//     - Drive the sign-fixed results: quotient negated if sign_q; remainder negated if sign_r.
//     - Stay in DONE while stall_ext=1; hi_o/lo_o hold stable.
//     - Go to IDLE on the first cycle with stall_ext=0. That is the cycle the instruction leaves E; no restart occurs.
// - div_stallE = ~flushE & ((IDLE & div_startE) | BUSY). It is combinational.
// - div_validE = DONE & ~flushE.
// - Latency: start seen in IDLE at cycle 0; div_stallE high cycles 0..WIDTH (33 cycles); DONE at cycle WIDTH+1.
// - flushE=1 in any state: div_stallE=0 that cycle; next state IDLE. A start that is also flushed is ignored.
// - stall_ext during BUSY: iteration continues; the divider ignores stall_ext outside DONE.
// - Divide by zero: the iterative result is lo=all-ones and hi=|a|, then sign fix applies. No exception is raised.
// - Signed overflow (0x80000000 / -1): result is the natural two's-complement wrap, lo=0x80000000 and hi=0.
// - resetn low mid-operation: immediate return to the reset values; no result is produced.
// CONFIGURATION
// - DIV_ZERO_FAST_EN defined:
//   - If |b|==0 is seen at start, IDLE goes directly to DONE with the same hi/lo values as the iterative path.
//   - div_stallE is high for 1 cycle only.
// - DIV_ZERO_FAST_EN undefined: divide by zero takes the full 33-cycle iterative path.
// TESTING
// - DIVU 100/7:
//   - div_stallE high exactly 33 cycles.
//   - Then lo_o=14, hi_o=2, div_validE=1.
// - DIV -7/2: lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
// - DIV 7/-2: lo_o=0xFFFFFFFD, hi_o=1.
// - flushE pulsed at BUSY count=10:
//   - div_stallE=0 that cycle; IDLE next cycle.
//   - A following DIVU 9/3 gives lo=3, hi=0 after a full 33 stall cycles.
// - Hold in DONE: stall_ext=1 for 5 cycles in DONE.
//   - hi/lo stable, div_stallE=0, no new BUSY entry.
//   - IDLE after stall_ext falls, with div_startE still high that cycle.
// - DIVU 5/0: lo=0xFFFFFFFF, hi=5.
//   - Without DIV_ZERO_FAST_EN: 33 stall cycles.
//   - With DIV_ZERO_FAST_EN: 1 stall cycle.
// - resetn asserted at BUSY count=20: all outputs 0 immediately; idle until the next start.

Source files
------------

// File: rtl/div_iter_if.sv
// Execute-stage divider bus: pipeline (master) <-> divider (slave).
// Signals:
//   div_startE, div_signedE, src_aE, src_bE  : operation request from E stage
//   flushE, stall_ext                         : hazard-unit cancel / cache hold
//   div_stallE, div_validE, hi_o, lo_o        : divider status and HI/LO results
interface div_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             div_startE;
    logic             div_signedE;
    logic [WIDTH-1:0] src_aE;
    logic [WIDTH-1:0] src_bE;
    logic             flushE;
    logic             stall_ext;
    logic             div_stallE;
    logic             div_validE;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output div_startE, div_signedE, src_aE, src_bE, flushE, stall_ext,
        input  div_stallE, div_validE, hi_o, lo_o
    );

    modport slave (
        input  div_startE, div_signedE, src_aE, src_bE, flushE, stall_ext,
        output div_stallE, div_validE, hi_o, lo_o
    );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU (E stage).
// hi_o = remainder, lo_o = quotient; one instruction in flight.
// Ports:
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset
//   bus     : div_iter_if.slave (request, flush/stall control, stall/valid, HI/LO)
// Optional build macro:
//   DIV_ZERO_FAST_EN : divide-by-zero skips the iteration and goes IDLE -> DONE.
module div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       resetn,
    div_iter_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q,   state_nxt;
    logic [CNT_W-1:0] count_q,   count_nxt;
    logic [WIDTH-1:0] rem_q,     rem_nxt;
    logic [WIDTH-1:0] quo_q,     quo_nxt;
    logic [WIDTH-1:0] div_q,     div_nxt;
    logic             neg_quo_q, neg_quo_nxt;
    logic             neg_rem_q, neg_rem_nxt;
    logic [WIDTH-1:0] hi_q,      hi_nxt;
    logic [WIDTH-1:0] lo_q,      lo_nxt;

    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] a_abs_c;
    logic [WIDTH-1:0] b_abs_c;
    logic [WIDTH:0]   shifted_c;
    logic             ge_c;
    logic [WIDTH-1:0] rem_step_c;
    logic [WIDTH-1:0] quo_step_c;

    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    // Operand magnitudes; DIVU treats both operands as unsigned.
    always_comb begin
        a_neg_c = bus.div_signedE & bus.src_aE[WIDTH-1];
        b_neg_c = bus.div_signedE & bus.src_bE[WIDTH-1];
        a_abs_c = neg_if(a_neg_c, bus.src_aE);
        b_abs_c = neg_if(b_neg_c, bus.src_bE);
    end

    // One restoring step: shift rem:quo left, subtract divisor when it fits.
    // The shifted remainder needs WIDTH+1 bits; the difference always fits WIDTH.
    always_comb begin
        shifted_c  = {rem_q, quo_q[WIDTH-1]};
        ge_c       = shifted_c >= {1'b0, div_q};
        rem_step_c = ge_c ? (shifted_c[WIDTH-1:0] - div_q) : shifted_c[WIDTH-1:0];
        quo_step_c = {quo_q[WIDTH-2:0], ge_c};
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt   = state_q;
        count_nxt   = count_q;
        rem_nxt     = rem_q;
        quo_nxt     = quo_q;
        div_nxt     = div_q;
        neg_quo_nxt = neg_quo_q;
        neg_rem_nxt = neg_rem_q;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;

        if (bus.flushE) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.div_startE) begin
                        rem_nxt     = '0;
                        quo_nxt     = a_abs_c;
                        div_nxt     = b_abs_c;
                        neg_quo_nxt = a_neg_c ^ b_neg_c;
                        neg_rem_nxt = a_neg_c;
                        count_nxt   = '0;
                        state_nxt   = BUSY;
`ifdef DIV_ZERO_FAST_EN
                        // Divide by zero: iterative result is known up front.
                        if (b_abs_c == '0) begin
                            hi_nxt    = neg_if(a_neg_c, a_abs_c);
                            lo_nxt    = neg_if(a_neg_c ^ b_neg_c, '1);
                            state_nxt = DONE;
                        end
`endif
                    end
                end
                BUSY: begin
                    rem_nxt   = rem_step_c;
                    quo_nxt   = quo_step_c;
                    count_nxt = count_q + CNT_W'(1);
                    if (count_q == LAST_CNT) begin
                        hi_nxt    = neg_if(neg_rem_q, rem_step_c);
                        lo_nxt    = neg_if(neg_quo_q, quo_step_c);
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    // Leaving DONE is the cycle the instruction leaves E.
                    if (!bus.stall_ext) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_nxt;
            count_q   <= count_nxt;
            rem_q     <= rem_nxt;
            quo_q     <= quo_nxt;
            div_q     <= div_nxt;
            neg_quo_q <= neg_quo_nxt;
            neg_rem_q <= neg_rem_nxt;
            hi_q      <= hi_nxt;
            lo_q      <= lo_nxt;
        end
    end

    // Stall and valid are combinational so the hazard unit sees them in the same cycle.
    assign bus.div_stallE = ~bus.flushE & (((state_q == IDLE) & bus.div_startE) | (state_q == BUSY));
    assign bus.div_validE = (state_q == DONE) & ~bus.flushE;
    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;
endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, signed/unsigned results, flush, DONE hold,
// divide-by-zero, signed overflow and asynchronous reset mid-operation.
module tb_div_iter;
    logic clk = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;
    int   n;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_STALLS = 1;
`else
    localparam int ZERO_STALLS = 33;
`endif

    always #5 clk = ~clk;

    div_iter_if #(.WIDTH(32)) bus ();

    div_iter #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation on the next cycle and counts stall cycles; ends at the
    // negedge of the first non-stalled cycle (bounded).
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int cnt);
        step();
        bus.flushE      = 1'b0;
        bus.div_signedE = sgn;
        bus.src_aE      = a;
        bus.src_bE      = b;
        bus.div_startE  = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.div_stallE) break;
            cnt++;
            step();
        end
    endtask

    // Checks a finished operation, then retires it and checks the return to idle.
    task automatic check_done(input string tag, input int cnt, input int exp_cnt,
                              input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        check({tag, "_stalls"}, 32'(cnt), 32'(exp_cnt));
        check({tag, "_valid"}, 32'(bus.div_validE), 32'd1);
        check({tag, "_lo"}, bus.lo_o, exp_lo);
        check({tag, "_hi"}, bus.hi_o, exp_hi);
        step();
        bus.div_startE = 1'b0;
        @(negedge clk);
        check({tag, "_idle_stall"}, 32'(bus.div_stallE), 32'd0);
        check({tag, "_idle_valid"}, 32'(bus.div_validE), 32'd0);
    endtask

    initial begin
        resetn          = 1'b0;
        bus.div_startE  = 1'b0;
        bus.div_signedE = 1'b0;
        bus.src_aE      = '0;
        bus.src_bE      = '0;
        bus.flushE      = 1'b0;
        bus.stall_ext   = 1'b0;
        repeat (2) step();
        check("rst_stall", 32'(bus.div_stallE), 32'd0);
        check("rst_valid", 32'(bus.div_validE), 32'd0);
        check("rst_hi", bus.hi_o, 32'd0);
        check("rst_lo", bus.lo_o, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Basic unsigned and signed results.
        run_div(1'b0, 32'd100, 32'd7, n);
        check_done("divu_100_7", n, 33, 32'd14, 32'd2);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, n);
        check_done("div_m7_2", n, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, n);
        check_done("div_7_m2", n, 33, 32'hFFFF_FFFD, 32'd1);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check_done("div_ovf", n, 33, 32'h8000_0000, 32'd0);

        // Divide by zero, unsigned and signed.
        run_div(1'b0, 32'd5, 32'd0, n);
        check_done("divu_5_0", n, ZERO_STALLS, 32'hFFFF_FFFF, 32'd5);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, n);
        check_done("div_m5_0", n, ZERO_STALLS, 32'd1, 32'hFFFF_FFFB);

        // A start that is flushed in the same cycle is ignored.
        step();
        bus.src_aE     = 32'd20;
        bus.src_bE     = 32'd4;
        bus.div_startE = 1'b1;
        bus.flushE     = 1'b1;
        @(negedge clk);
        check("flush_start_stall", 32'(bus.div_stallE), 32'd0);
        step();
        bus.div_startE = 1'b0;
        bus.flushE     = 1'b0;
        @(negedge clk);
        check("flush_start_idle", 32'(bus.div_stallE), 32'd0);

        // Flush at BUSY count=10, then a fresh DIVU 9/3 must take the full latency.
        step();
        bus.div_signedE = 1'b0;
        bus.src_aE      = 32'd1000;
        bus.src_bE      = 32'd3;
        bus.div_startE  = 1'b1;
        repeat (11) step();
        bus.flushE = 1'b1;
        @(negedge clk);
        check("flush_busy_stall", 32'(bus.div_stallE), 32'd0);
        check("flush_busy_valid", 32'(bus.div_validE), 32'd0);
        run_div(1'b0, 32'd9, 32'd3, n);
        check_done("after_flush_9_3", n, 33, 32'd3, 32'd0);

        // Hold in DONE for 5 cycles under stall_ext; stall_ext is ignored while BUSY.
        bus.stall_ext = 1'b1;
        run_div(1'b0, 32'd50, 32'd6, n);
        check("hold_stalls", 32'(n), 32'd33);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) begin
                step();
                @(negedge clk);
            end
            check("hold_valid", 32'(bus.div_validE), 32'd1);
            check("hold_stall", 32'(bus.div_stallE), 32'd0);
            check("hold_lo", bus.lo_o, 32'd8);
            check("hold_hi", bus.hi_o, 32'd2);
        end
        step();
        bus.stall_ext = 1'b0;
        @(negedge clk);
        check("release_valid", 32'(bus.div_validE), 32'd1);
        check("release_stall", 32'(bus.div_stallE), 32'd0);
        step();
        bus.div_startE = 1'b0;
        @(negedge clk);
        check("release_idle_stall", 32'(bus.div_stallE), 32'd0);
        check("release_idle_valid", 32'(bus.div_validE), 32'd0);
        check("release_lo_kept", bus.lo_o, 32'd8);

        // Asynchronous reset at BUSY count=20.
        step();
        bus.src_aE     = 32'd100;
        bus.src_bE     = 32'd7;
        bus.div_startE = 1'b1;
        repeat (21) step();
        resetn         = 1'b0;
        bus.div_startE = 1'b0;
        #1;
        check("midrst_stall", 32'(bus.div_stallE), 32'd0);
        check("midrst_valid", 32'(bus.div_validE), 32'd0);
        check("midrst_hi", bus.hi_o, 32'd0);
        check("midrst_lo", bus.lo_o, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("postrst_stall", 32'(bus.div_stallE), 32'd0);
            check("postrst_valid", 32'(bus.div_validE), 32'd0);
        end
        run_div(1'b0, 32'hFFFF_FFFF, 32'd16, n);
        check_done("postrst_div", n, 33, 32'h0FFF_FFFF, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
